// File: rtl/gpio_cfg_sequencer.sv
// Serial loader for a chain of GPIO pad config blocks, last pad first, MSB first.
// Optional chain readback (XOR of returned words) under GPIO_CFG_READBACK_EN.
module gpio_cfg_sequencer #(
    parameter int NUM_GPIO = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(NUM_GPIO)-1:0] cfg_idx,
    input  logic [CFG_BITS-1:0]         cfg_word,
    output logic                        serial_clock,
    output logic                        serial_data,
    output logic                        serial_load,
    output logic                        serial_resetn
`ifdef GPIO_CFG_READBACK_EN
    ,
    input  logic                        serial_return,
    output logic [CFG_BITS-1:0]         readback_sum
`endif
);

    localparam int IDX_W = $clog2(NUM_GPIO);
    localparam int DIV_W = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = ($clog2(CFG_BITS) > 0) ? $clog2(CFG_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GPIO - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        FIN
    } state_t;

    state_t              state;
    logic                fetch_ph;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [CFG_BITS-1:0] shreg;
    logic [CFG_BITS-1:0] shreg_next;

    always_comb begin
        shreg_next = shreg << 1;
    end

`ifdef GPIO_CFG_READBACK_EN
    logic [CFG_BITS-1:0] rb_shift;
    logic [CFG_BITS-1:0] rb_next;

    always_comb begin
        rb_next = {rb_shift[CFG_BITS-2:0], serial_return};
    end
`endif

    // cfg_idx doubles as the word counter: it only moves on entry to FETCH.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            fetch_ph      <= 1'b0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            cfg_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            serial_clock  <= 1'b0;
            serial_data   <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b0;
`ifdef GPIO_CFG_READBACK_EN
            rb_shift      <= '0;
            readback_sum  <= '0;
`endif
        end else begin
            serial_resetn <= 1'b1;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        cfg_idx  <= LAST_IDX;
                        fetch_ph <= 1'b0;
`ifdef GPIO_CFG_READBACK_EN
                        readback_sum <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (!fetch_ph) begin
                        fetch_ph <= 1'b1;
                    end else begin
                        shreg       <= cfg_word;
                        serial_data <= cfg_word[CFG_BITS-1];
                        bit_cnt     <= '0;
                        div_cnt     <= '0;
                        state       <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt      <= '0;
                        serial_clock <= 1'b1;
                        state        <= SHIFT_HI;
`ifdef GPIO_CFG_READBACK_EN
                        // Sampled at the edge that raises serial_clock: the tail before it shifts.
                        rb_shift <= rb_next;
                        if (bit_cnt == BIT_LAST) begin
                            readback_sum <= readback_sum ^ rb_next;
                        end
`endif
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt      <= '0;
                        serial_clock <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (cfg_idx == '0) begin
                                serial_load <= 1'b1;
                                state       <= LOAD;
                            end else begin
                                cfg_idx  <= cfg_idx - 1'b1;
                                fetch_ph <= 1'b0;
                                state    <= FETCH;
                            end
                        end else begin
                            bit_cnt     <= bit_cnt + 1'b1;
                            shreg       <= shreg_next;
                            serial_data <= shreg_next[CFG_BITS-1];
                            state       <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt     <= '0;
                        serial_load <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= FIN;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Scoreboard bench: a small (2x4, div 1) instance and a default instance.
// Expected serial bits are queued at start and popped on each serial_clock rise.
module tb_gpio_cfg_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // small instance
    logic       start_s = 1'b0;
    logic       busy_s, done_s, sclk_s, sdat_s, sload_s, srstn_s;
    logic [0:0] idx_s;
    logic [3:0] word_s = '0;
    logic [3:0] tbl_s [0:1];
    always @(posedge clk) word_s <= tbl_s[idx_s];

    // default instance
    logic        start_d = 1'b0;
    logic        busy_d, done_d, sclk_d, sdat_d, sload_d, srstn_d;
    logic [5:0]  idx_d;
    logic [12:0] word_d = 13'h1803;

    logic [7:0] chain_s = '0;
`ifdef GPIO_CFG_READBACK_EN
    logic        sret_s;
    logic [3:0]  rb_sum_s;
    logic [12:0] rb_sum_d;
    assign sret_s = chain_s[7];
`endif

    gpio_cfg_sequencer #(.NUM_GPIO(2), .CFG_BITS(4), .CLK_DIV(1)) dut_s (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_s), .busy(busy_s), .done(done_s),
        .cfg_idx(idx_s), .cfg_word(word_s), .serial_clock(sclk_s), .serial_data(sdat_s),
        .serial_load(sload_s), .serial_resetn(srstn_s)
`ifdef GPIO_CFG_READBACK_EN
        , .serial_return(sret_s), .readback_sum(rb_sum_s)
`endif
    );

    gpio_cfg_sequencer dut_d (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start_d), .busy(busy_d), .done(done_d),
        .cfg_idx(idx_d), .cfg_word(word_d), .serial_clock(sclk_d), .serial_data(sdat_d),
        .serial_load(sload_d), .serial_resetn(srstn_d)
`ifdef GPIO_CFG_READBACK_EN
        , .serial_return(1'b0), .readback_sum(rb_sum_d)
`endif
    );

    bit   exp_q_s[$];
    bit   exp_q_d[$];
    bit   e_s, e_d;
    int   rises_s = 0, loads_s = 0, loadcyc_s = 0, dones_s = 0;
    int   rises_d = 0, loads_d = 0, loadcyc_d = 0, dones_d = 0;
    logic prev_sclk_s = 1'b0, prev_load_s = 1'b0, prev_sclk_d = 1'b0, prev_load_d = 1'b0;

    always @(negedge clk) begin
        if (sclk_s && !prev_sclk_s) begin
            rises_s++;
            chain_s = {chain_s[6:0], sdat_s};
            checks++;
            if (exp_q_s.size() == 0) begin
                failures++;
                $display("FAIL small_bit: extra rising edge, data=%b, required none", sdat_s);
            end else begin
                e_s = exp_q_s.pop_front();
                if (sdat_s !== e_s) begin
                    failures++;
                    $display("FAIL small_bit: rise %0d data=%b required %b", rises_s, sdat_s, e_s);
                end
            end
        end
        if (sload_s) begin
            loadcyc_s++;
            if (!prev_load_s) loads_s++;
            checks++;
            if (sclk_s !== 1'b0) begin
                failures++;
                $display("FAIL small_load_clk: serial_clock=%b required 0 during load", sclk_s);
            end
        end
        if (done_s) dones_s++;
        prev_sclk_s = sclk_s;
        prev_load_s = sload_s;
    end

    always @(negedge clk) begin
        if (sclk_d && !prev_sclk_d) begin
            rises_d++;
            checks++;
            if (exp_q_d.size() == 0) begin
                failures++;
                $display("FAIL dflt_bit: extra rising edge, data=%b, required none", sdat_d);
            end else begin
                e_d = exp_q_d.pop_front();
                if (sdat_d !== e_d) begin
                    failures++;
                    $display("FAIL dflt_bit: rise %0d data=%b required %b", rises_d, sdat_d, e_d);
                end
            end
        end
        if (sload_d) begin
            loadcyc_d++;
            if (!prev_load_d) loads_d++;
            checks++;
            if (sclk_d !== 1'b0) begin
                failures++;
                $display("FAIL dflt_load_clk: serial_clock=%b required 0 during load", sclk_d);
            end
        end
        if (done_d) dones_d++;
        prev_sclk_d = sclk_d;
        prev_load_d = sload_d;
    end

    task automatic push_s(input logic [3:0] w1, input logic [3:0] w0);
        for (int i = 3; i >= 0; i--) exp_q_s.push_back(w1[i]);
        for (int i = 3; i >= 0; i--) exp_q_s.push_back(w0[i]);
    endtask

    // Starts a load, re-pulses start at r1/r2, checks busy every cycle and done timing.
    task automatic run(input bit big, input int r1, input int r2, input int exp_n, input string name);
        int   t0, n;
        bit   seen;
        logic b, d;
        @(negedge clk);
        if (big) start_d = 1'b1; else start_s = 1'b1;
        t0 = cyc;
        seen = 0;
        n = 0;
        while (!seen && n < exp_n + 50) begin
            @(negedge clk);
            n = cyc - t0;
            start_s = !big && (n == r1 || n == r2);
            start_d = big && (n == r1 || n == r2);
            b = big ? busy_d : busy_s;
            d = big ? done_d : done_s;
            if (d === 1'b1) begin
                seen = 1;
                checks += 2;
                if (n != exp_n) begin
                    failures++;
                    $display("FAIL %s_done_cycle: got %0d required %0d", name, n, exp_n);
                end
                if (b !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_busy_at_done: got %b required 0", name, b);
                end
            end else begin
                checks++;
                if (b !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_busy: cycle %0d got %b required 1", name, n, b);
                end
            end
        end
        start_s = 1'b0;
        start_d = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles, required at %0d", name, n, exp_n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks += 2;
        if ({busy_s, done_s, sclk_s, sdat_s, sload_s, idx_s, srstn_s} !== 7'b0) begin
            failures++;
            $display("FAIL reset_small: outputs=%b required 0", {busy_s, done_s, sclk_s, sdat_s, sload_s, idx_s, srstn_s});
        end
        if ({busy_d, done_d, sclk_d, sdat_d, sload_d, idx_d, srstn_d} !== 12'b0) begin
            failures++;
            $display("FAIL reset_dflt: outputs=%b required 0", {busy_d, done_d, sclk_d, sdat_d, sload_d, idx_d, srstn_d});
        end
`ifdef GPIO_CFG_READBACK_EN
        checks++;
        if (rb_sum_s !== 4'h0) begin
            failures++;
            $display("FAIL reset_rbsum: got %h required 0", rb_sum_s);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({srstn_s, srstn_d} !== 2'b11) begin
            failures++;
            $display("FAIL reset_resetn_release: got %b required 11", {srstn_s, srstn_d});
        end
    endtask

    task automatic test_basic();
        int r0, l0, c0, d0;
        tbl_s[1] = 4'hA;
        tbl_s[0] = 4'h3;
        push_s(4'hA, 4'h3);
        r0 = rises_s; l0 = loads_s; c0 = loadcyc_s; d0 = dones_s;
        run(1'b0, -1, -1, 22, "basic");
        repeat (5) @(negedge clk);
        checks += 5;
        if (exp_q_s.size() != 0) begin failures++; $display("FAIL basic_bits_left: got %0d required 0", exp_q_s.size()); end
        if (rises_s - r0 != 8) begin failures++; $display("FAIL basic_rises: got %0d required 8", rises_s - r0); end
        if (loads_s - l0 != 1) begin failures++; $display("FAIL basic_loads: got %0d required 1", loads_s - l0); end
        if (loadcyc_s - c0 != 1) begin failures++; $display("FAIL basic_load_len: got %0d required 1", loadcyc_s - c0); end
        if (dones_s - d0 != 1) begin failures++; $display("FAIL basic_dones: got %0d required 1", dones_s - d0); end
    endtask

    task automatic test_back_to_back();
        int r0, d0;
        push_s(4'hA, 4'h3);
        push_s(4'hA, 4'h3);
        r0 = rises_s; d0 = dones_s;
        run(1'b0, 5, 21, 22, "ignore");
        run(1'b0, -1, -1, 22, "second");
        repeat (5) @(negedge clk);
        checks += 3;
        if (exp_q_s.size() != 0) begin failures++; $display("FAIL b2b_bits_left: got %0d required 0", exp_q_s.size()); end
        if (rises_s - r0 != 16) begin failures++; $display("FAIL b2b_rises: got %0d required 16", rises_s - r0); end
        if (dones_s - d0 != 2) begin failures++; $display("FAIL b2b_dones: got %0d required 2", dones_s - d0); end
    endtask

`ifdef GPIO_CFG_READBACK_EN
    task automatic test_readback();
        logic [3:0] exp_sum;
        for (int k = 0; k < 3; k++) begin
            tbl_s[1] = (k == 0) ? 4'h5 : 4'hA;
            tbl_s[0] = (k == 0) ? 4'hC : 4'h3;
            push_s(tbl_s[1], tbl_s[0]);
            exp_sum = chain_s[7:4] ^ chain_s[3:0];
            run(1'b0, -1, -1, 22, "readback");
            checks++;
            if (rb_sum_s !== exp_sum) begin
                failures++;
                $display("FAIL readback_sum: load %0d got %h required %h", k, rb_sum_s, exp_sum);
            end
        end
    endtask
`endif

    task automatic test_abort();
        int t0, r0, l0, d0;
        push_s(4'hA, 4'h3);
        r0 = rises_s; l0 = loads_s; d0 = dones_s;
        @(negedge clk);
        start_s = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_s = 1'b0;
        while (cyc - t0 < 9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks += 2;
        if ({busy_s, done_s, sclk_s, sdat_s, sload_s, idx_s, srstn_s} !== 7'b0) begin
            failures++;
            $display("FAIL abort_outputs: got %b required 0", {busy_s, done_s, sclk_s, sdat_s, sload_s, idx_s, srstn_s});
        end
        if (rises_s - r0 != 3) begin failures++; $display("FAIL abort_rises: got %0d required 3", rises_s - r0); end
        exp_q_s.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checks += 3;
        if (dones_s - d0 != 0) begin failures++; $display("FAIL abort_done: got %0d required 0", dones_s - d0); end
        if (loads_s - l0 != 0) begin failures++; $display("FAIL abort_load: got %0d required 0", loads_s - l0); end
        if (busy_s !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b required 0", busy_s); end
    endtask

    task automatic test_default();
        int r0, l0, c0;
        logic [12:0] w;
        w = 13'h1803;
        word_d = w;
        for (int p = 0; p < 38; p++)
            for (int i = 12; i >= 0; i--) exp_q_d.push_back(w[i]);
        r0 = rises_d; l0 = loads_d; c0 = loadcyc_d;
        run(1'b1, -1, -1, 2055, "dflt");
        repeat (5) @(negedge clk);
        checks += 4;
        if (exp_q_d.size() != 0) begin failures++; $display("FAIL dflt_bits_left: got %0d required 0", exp_q_d.size()); end
        if (rises_d - r0 != 494) begin failures++; $display("FAIL dflt_rises: got %0d required 494", rises_d - r0); end
        if (loads_d - l0 != 1) begin failures++; $display("FAIL dflt_loads: got %0d required 1", loads_d - l0); end
        if (loadcyc_d - c0 != 2) begin failures++; $display("FAIL dflt_load_len: got %0d required 2", loadcyc_d - c0); end
    endtask

    initial begin
        tbl_s[0] = 4'h0;
        tbl_s[1] = 4'h0;
        test_reset();
        test_basic();
        test_back_to_back();
`ifdef GPIO_CFG_READBACK_EN
        test_readback();
`endif
        test_default();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
